// File: rtl/merge_arb.sv
// Round-robin arbiter merging N native-bus masters onto one shared slave.
// Optional slave-ready watchdog: define MERGE_ARB_TIMEOUT_EN.
module merge_arb #(
  parameter  int N_MASTERS = 2,
  parameter  int ADDR_W    = 32,
  parameter  int TIMEOUT   = 255,
  localparam int NM_W      = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_MASTERS*(ADDR_W+37)-1:0]  m_req,
  output logic [N_MASTERS*33-1:0]           m_resp,
  output logic [ADDR_W+36:0]                s_req,
  input  logic [32:0]                       s_resp,
  output logic [NM_W-1:0]                   grant,
  output logic                              busy
`ifdef MERGE_ARB_TIMEOUT_EN
  ,
  output logic                              timeout_err
`endif
);

  localparam int RW = ADDR_W + 37;
  localparam int NP = 1 << NM_W;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          r_state;
  logic [NM_W-1:0] r_grant;
  logic [NM_W-1:0] r_last;

  logic [RW-1:0]   w_slice [NP];
  logic [NP-1:0]   w_valid;
  logic            w_found;
  logic [NM_W-1:0] w_winner;
  logic            w_busy;
  logic            w_gvalid;
  logic            w_rdy;
  logic            w_to;
  logic            w_fire;
  logic            w_done;

  // Pad to a power of two so grant-indexed lookups never go out of range
  for (genvar gi = 0; gi < NP; gi++) begin : g_sl
    if (gi < N_MASTERS) begin : g_m
      assign w_slice[gi] = m_req[gi*RW +: RW];
    end else begin : g_z
      assign w_slice[gi] = '0;
    end
    assign w_valid[gi] = w_slice[gi][RW-1];
  end

  always_comb begin
    w_found  = 1'b0;
    w_winner = r_last;
    for (int k = 1; k <= N_MASTERS; k++) begin
      automatic int idx = (int'(r_last) + k) % N_MASTERS;
      if (!w_found && w_valid[NM_W'(idx)]) begin
        w_found  = 1'b1;
        w_winner = NM_W'(idx);
      end
    end
  end

  assign w_busy   = (r_state == BUSY);
  assign w_gvalid = w_valid[r_grant];
  assign w_rdy    = s_resp[0];

`ifdef MERGE_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [CW-1:0] r_cnt;
  assign w_to        = w_busy && (r_cnt == CW'(TIMEOUT));
  assign timeout_err = w_fire;
`else
  assign w_to = 1'b0;
`endif

  // A genuine slave ready in the watchdog cycle is forwarded, not replaced
  assign w_fire = w_to && w_gvalid && !w_rdy;
  assign w_done = w_busy && (!w_gvalid || w_rdy || w_to);

  assign grant = r_grant;
  assign busy  = w_busy;
  assign s_req = (w_busy && !w_to) ? w_slice[r_grant] : '0;

  always_comb begin
    m_resp = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (w_busy && w_gvalid && (r_grant == NM_W'(i)))
        m_resp[i*33 +: 33] = w_fire ? {32'hDEAD_BEEF, 1'b1} : s_resp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= NM_W'(N_MASTERS - 1);
`ifdef MERGE_ARB_TIMEOUT_EN
      r_cnt   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant <= w_winner;
            r_state <= BUSY;
`ifdef MERGE_ARB_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end
        BUSY: begin
          if (w_done) begin
            r_state <= IDLE;
            r_last  <= r_grant;
          end else begin
`ifdef MERGE_ARB_TIMEOUT_EN
            r_cnt   <= r_cnt + 1'b1;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_merge_arb.sv
// Directed bench for merge_arb (4 masters) with a transaction-level
// reference model compared against the DUT every cycle.
module tb_merge_arb;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int TO = 8;
  localparam int RW = AW + 37;

  logic              clk;
  logic              rst;
  logic [N*RW-1:0]   m_req;
  logic [N*33-1:0]   m_resp;
  logic [RW-1:0]     s_req;
  logic [32:0]       s_resp;
  logic [1:0]        grant;
  logic              busy;
`ifdef MERGE_ARB_TIMEOUT_EN
  logic              timeout_err;
`endif

  int n_vec = 0;
  int n_err = 0;
  bit run   = 0;

  merge_arb #(.N_MASTERS(N), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .m_req(m_req),
    .m_resp(m_resp),
    .s_req(s_req),
    .s_resp(s_resp),
    .grant(grant),
    .busy(busy)
`ifdef MERGE_ARB_TIMEOUT_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [255:0] a, logic [255:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // Reference model: one outstanding transaction, owner, rotation pointer
  logic       md_act;
  int         md_own;
  int         md_last;
  int         md_wait;
  logic [1:0] md_grant;

  function automatic bit vld(int i);
    return m_req[i*RW + RW-1];
  endfunction

  function automatic int rr_pick(int last);
    for (int k = 1; k <= N; k++) begin
      if (vld((last + k) % N)) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic bit m_eto();
`ifdef MERGE_ARB_TIMEOUT_EN
    return md_act && (md_wait == TO);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      md_act   <= 1'b0;
      md_own   <= 0;
      md_last  <= N - 1;
      md_wait  <= 0;
      md_grant <= '0;
    end else if (!md_act) begin
      if (rr_pick(md_last) >= 0) begin
        md_act   <= 1'b1;
        md_own   <= rr_pick(md_last);
        md_grant <= 2'(rr_pick(md_last));
        md_wait  <= 0;
      end
    end else if (!vld(md_own) || s_resp[0] || m_eto()) begin
      md_act  <= 1'b0;
      md_last <= md_own;
    end else begin
      md_wait <= md_wait + 1;
    end
  end

  always @(negedge clk) begin : cmp
    logic [RW-1:0]   es;
    logic [N*33-1:0] er;
    logic            ev;
    logic            eto;
    if (run) begin
      ev  = md_act && vld(md_own);
      eto = m_eto();
      es  = (md_act && !eto) ? m_req[md_own*RW +: RW] : '0;
      er  = '0;
      if (ev)
        er[md_own*33 +: 33] = (eto && !s_resp[0]) ?
                              {32'hDEAD_BEEF, 1'b1} : s_resp;
      chk("s_req", s_req, es);
      chk("m_resp", m_resp, er);
      chk("busy", busy, md_act);
      chk("grant", grant, md_grant);
`ifdef MERGE_ARB_TIMEOUT_EN
      chk("timeout_err", timeout_err, ev && eto && !s_resp[0]);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setm(int i, bit v, logic [31:0] a, logic [31:0] d,
                      logic [3:0] s);
    m_req[i*RW +: RW] = {v, a, d, s};
  endtask

  task automatic do_reset();
    m_req  = '0;
    s_resp = '0;
    rst    = 1'b1;
    cyc();
    rst    = 1'b0;
  endtask

  int seq[$];
  bit pb;
  int bi;
  int fired;

  initial begin
    rst    = 1'b0;
    m_req  = '0;
    s_resp = '0;
    #1 rst = 1'b1;
    run = 1;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant, 2'd0);
    chk("rst_sreq", s_req, '0);
    chk("rst_mresp", m_resp, '0);
    cyc();
    rst = 1'b0;

    // single request, slave ready after 3 cycles
    setm(1, 1, 32'h100, 32'hA5A5_A5A5, 4'hF);
    @(negedge clk) chk("t1_c0_busy", busy, 1'b0);
    cyc();
    @(negedge clk) chk("t1_c1_valid", s_req[RW-1], 1'b1);
    chk("t1_c1_addr", s_req[RW-2 -: AW], 32'h100);
    cyc();
    cyc();
    cyc();
    s_resp = {32'hCAFE_0001, 1'b1};
    @(negedge clk) chk("t1_c4_ready", m_resp[1*33 +: 33],
                       {32'hCAFE_0001, 1'b1});
    cyc();
    s_resp = '0;
    setm(1, 0, 0, 0, 0);
    @(negedge clk) chk("t1_c5_busy", busy, 1'b0);
    cyc();

    // contention: all four request, slave ready on first cycle
    do_reset();
    for (int i = 0; i < N; i++) setm(i, 1, 32'h1000 * (i + 1), i, 4'hF);
    s_resp = {32'h0BAD_F00D, 1'b1};
    pb = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (busy && !pb) seq.push_back(int'(grant));
      pb = busy;
      cyc();
    end
    chk("t2_count", (seq.size() >= 5), 1'b1);
    if (seq.size() >= 5) begin
      chk("t2_g0", seq[0], 0);
      chk("t2_g1", seq[1], 1);
      chk("t2_g2", seq[2], 2);
      chk("t2_g3", seq[3], 3);
      chk("t2_g4", seq[4], 0);
    end

    // read data routing to master 2 only
    do_reset();
    setm(2, 1, 32'h200, 0, 4'h0);
    s_resp = {32'h1234_5678, 1'b1};
    cyc();
    @(negedge clk);
    chk("t3_m2", m_resp[2*33 +: 33], {32'h1234_5678, 1'b1});
    chk("t3_m0", m_resp[0 +: 33], '0);
    chk("t3_m1", m_resp[33 +: 33], '0);
    chk("t3_m3", m_resp[3*33 +: 33], '0);
    cyc();
    setm(2, 0, 0, 0, 0);
    s_resp = '0;
    cyc();

    // abort: master 0 drops valid while granted
    do_reset();
    setm(0, 1, 32'h300, 1, 4'h1);
    setm(1, 1, 32'h400, 2, 4'h3);
    cyc();
    @(negedge clk);
    chk("t4_c1_busy", busy, 1'b1);
    chk("t4_c1_grant", grant, 2'd0);
    cyc();
    setm(0, 0, 0, 0, 0);
    @(negedge clk) chk("t4_c2_rdy0", m_resp[0], 1'b0);
    cyc();
    @(negedge clk) chk("t4_c3_busy", busy, 1'b0);
    cyc();
    @(negedge clk);
    chk("t4_c4_busy", busy, 1'b1);
    chk("t4_c4_grant", grant, 2'd1);
    s_resp = {32'h0, 1'b1};
    cyc();
    setm(1, 0, 0, 0, 0);
    s_resp = '0;
    cyc();

    // reset in the middle of a transaction
    do_reset();
    setm(3, 1, 32'h500, 3, 4'hC);
    cyc();
    @(negedge clk);
    chk("t5_busy", busy, 1'b1);
    chk("t5_grant", grant, 2'd3);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t5_rst_sreq", s_req, '0);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_mresp", m_resp, '0);
    cyc();
    rst = 1'b0;
    setm(0, 1, 32'h600, 4, 4'hF);
    cyc();
    @(negedge clk);
    chk("t5_prio_busy", busy, 1'b1);
    chk("t5_prio_grant", grant, 2'd0);
    setm(0, 0, 0, 0, 0);
    setm(3, 0, 0, 0, 0);
    s_resp = {32'h0, 1'b1};
    cyc();
    s_resp = '0;
    cyc();

`ifdef MERGE_ARB_TIMEOUT_EN
    // watchdog with a slave that never answers
    do_reset();
    setm(1, 1, 32'h700, 5, 4'hF);
    bi    = 0;
    fired = -1;
    for (int c = 0; c < 40 && fired < 0; c++) begin
      cyc();
      @(negedge clk);
      if (busy) begin
        if (timeout_err) begin
          fired = bi;
          chk("t6_rdata", m_resp[1*33 +: 33], {32'hDEAD_BEEF, 1'b1});
          chk("t6_sreq", s_req, '0);
        end else begin
          bi++;
        end
      end
    end
    chk("t6_fire_cycle", fired, TO);
    cyc();
    @(negedge clk);
    chk("t6_idle", busy, 1'b0);
    chk("t6_err_low", timeout_err, 1'b0);
    setm(1, 0, 0, 0, 0);
    cyc();
`endif

    cyc();
    run = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/merge_arb.md
Name: merge_arb

Overview:
- Round-robin arbiter that shares one native-bus slave port among N_MASTERS native-bus masters.
- It is the dual of the address-split demux: it sits in front of a single shared slave (memory, peripheral bus root) and serialises requests from CPU instruction/data ports, DMA and debug masters.
- Grant is held for one complete transaction, which ends on slave ready.

Parameters:
- N_MASTERS, 2, number of requesting masters (>=1); index width NM_W = max(1, clog2(N_MASTERS)).
- ADDR_W, 32, address width of every master request and of the slave request.
- TIMEOUT, 255, slave-ready watchdog limit in cycles; used only with MERGE_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- m_req  in  N_MASTERS*(ADDR_W+37)  concatenated master requests; master i occupies slice i. Each slice is {valid[1], addr[ADDR_W], wdata[32], wstrb[4]}, with valid at the MSB.
- m_resp  out  N_MASTERS*33  concatenated master responses. Each slice is {rdata[32], ready[1]}.
- s_req  out  ADDR_W+37  request to the shared slave, same layout as one m_req slice.
- s_resp  in  33  slave response {rdata, ready}.
- grant  out  NM_W  index of the current/last granted master.
- busy  out  1  high while a transaction is in progress (state BUSY).
- timeout_err  out  1  one-cycle error pulse; present only with MERGE_ARB_TIMEOUT_EN.

Behaviour:
- Reset values (async, immediate): state=IDLE, grant=0, last=N_MASTERS-1 so master 0 has first priority, busy=0, s_req=all zeros, m_resp=all zeros, timeout_err=0.
- IDLE:
  - Search masters last+1, last+2, ... modulo N_MASTERS for the first asserted valid.
  - If one is found, register grant=winner and go to BUSY on the next edge.
  - If none is found, stay in IDLE.
  - s_req stays zero in IDLE.
- BUSY:
  - s_req = m_req slice[grant], passed through combinationally.
  - m_resp slice[grant] = s_resp, combinational.
  - All other m_resp slices are zero.
- Completion: when s_resp.ready=1 in BUSY, the granted master sees ready and rdata in that same cycle. On the next edge: state=IDLE, last=grant.
- Latency: a request presented in IDLE at cycle 0 reaches s_req at cycle 1. Minimum occupancy is 2 cycles per transaction, with one IDLE cycle between back-to-back grants.
- Abort: if the granted master's valid is 0 in BUSY (protocol violation), no response is given. Return to IDLE on the next edge with last=grant.
- Fairness:
  - A master that has just completed has the lowest priority in the next arbitration.
  - Any continuously requesting master is served within N_MASTERS transactions.
- Simultaneous requests in IDLE: only the rotation winner is granted. The others remain pending, with valid held by their masters.
- New requests arriving during BUSY are ignored until the next IDLE.
- Ready and valid arriving in the same BUSY cycle as a new request from another master: completion takes precedence; arbitration happens in the following IDLE cycle.
- N_MASTERS=1: grant is constant 0 and the same state machine applies.
- Reset asserted mid-transaction: immediate return to reset values. The slave sees valid drop asynchronously, and no ready is forwarded.

Optional Feature:
- MERGE_ARB_TIMEOUT_EN defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without ready.
  - When the count reaches TIMEOUT, the arbiter forces ready=1 and rdata=32'hDEAD_BEEF to the granted master for one cycle, and holds s_req at zero that cycle.
  - timeout_err pulses high for that one cycle; then IDLE with last=grant.
  - A real ready in the same cycle wins: it is forwarded normally, with no error.
- MERGE_ARB_TIMEOUT_EN not defined: no counter, no timeout_err port, and BUSY waits indefinitely for ready.

Test Plan:
- Single request: master 1 valid, addr=0x100, wstrb=0xF; slave ready after 3 cycles -> s_req valid from cycle 1; m_resp[1].ready=1 in cycle 4; busy=0 in cycle 5.
- Contention, N_MASTERS=4: all masters request continuously with a ready-on-first-cycle slave -> grant sequence 0,1,2,3,0; no master's ready is asserted while another is granted.
- Read data routing: master 2 reads and the slave returns rdata=0x12345678 -> only m_resp[2] carries it; all other slices are zero.
- Abort: master 0 drops valid one cycle into BUSY -> IDLE the next cycle, no ready to master 0, and master 1 wins the next arbitration.
- Reset mid-BUSY: assert rst between edges -> s_req=0 and busy=0 immediately; after release, master 0 has first priority.
- With MERGE_ARB_TIMEOUT_EN and TIMEOUT=8, slave never ready -> ready with rdata 0xDEADBEEF and a one-cycle timeout_err pulse at BUSY cycle 8; then IDLE.
